// File: rtl/axis_uart_tx_fifo_pkg.sv
// Shared types and constants for the AXIS-fed UART transmitter.
// Contents:
//   parity_mode_e : decoded parity selection (NONE, ODD, EVEN, MARK, SPACE)
//   tx_state_e    : transmitter FSM states
//   MIN_DATA_BITS / MAX_DATA_BITS : legal character length range
//   decode_parity : maps the raw 3-bit register field to parity_mode_e
//   clamp_bits    : clamps a requested character length into the legal range
package uart_pkg;

    localparam int MIN_DATA_BITS = 5;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        ODD   = 3'd1,
        EVEN  = 3'd2,
        MARK  = 3'd3,
        SPACE = 3'd4
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Register values 5..7 are reserved and mean "no parity bit".
    function automatic parity_mode_e decode_parity(input logic [2:0] mode);
        case (mode)
            3'd1:    return ODD;
            3'd2:    return EVEN;
            3'd3:    return MARK;
            3'd4:    return SPACE;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
        if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
        if (int'(req) > max_bits)      return 4'(max_bits);
        return req;
    endfunction

endpackage

// File: rtl/axis_uart_tx_fifo_if.sv
// AXI-Stream character channel into the UART transmitter.
//   saxis_data_i   : character, LSB transmitted first
//   saxis_tvalid_i : source has a character
//   saxis_tready_o : transmitter FIFO can accept a character
// Handshake: a transfer happens on every rising clk edge where both
// saxis_tvalid_i and saxis_tready_o are 1. The master holds data/valid stable
// until that edge; ready does not depend on valid.
interface axis_uart_tx_fifo_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] saxis_data_i;
    logic              saxis_tvalid_i;
    logic              saxis_tready_o;

    modport master (
        output saxis_data_i,
        output saxis_tvalid_i,
        input  saxis_tready_o
    );

    modport slave (
        input  saxis_data_i,
        input  saxis_tvalid_i,
        output saxis_tready_o
    );
endinterface

// File: rtl/axis_uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered read data.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointers/count cleared)
//   wr_en, wr_data : write request and data, ignored when full
//   rd_en      : pop request, ignored when empty
//   rd_data    : entry popped on the previous pop edge
//   full, empty, level : occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             push, pop;

    assign full    = (count_q == DEPTH_L);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = rd_data_q;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two
    // makes the increment wrap for free.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; the cleared count makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/axis_uart_tx_fifo.sv
// UART transmitter fed from an AXI-Stream slave through an internal FIFO.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   saxis           : AXIS character input (slave modport)
//   uart_tx         : registered serial output, idles high
//   delitel         : clocks per bit (0 behaves as 1)
//   data_bits       : character length, clamped to 5..DATA_W
//   stop_bit_num    : 0 = one stop bit, 1 = two
//   parity_bit_mode : 0 none, 1 odd, 2 even, 3 mark, 4 space, 5-7 none
//   tx_en           : allows new frames to start
//   fifo_level      : FIFO occupancy
//   tx_busy         : a frame is in progress
//   tx_done         : one-cycle pulse when a frame's last stop bit ends
//   dbg_state       : current FSM state
module axis_uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axis_uart_tx_fifo_if.slave            saxis,
    output logic                          uart_tx,
    input  logic [DIV_W-1:0]              delitel,
    input  logic [3:0]                    data_bits,
    input  logic                          stop_bit_num,
    input  logic [2:0]                    parity_bit_mode,
    input  logic                          tx_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          tx_done,
    output tx_state_e                     dbg_state
);
    localparam int CHAR_MAX = (DATA_W > MAX_DATA_BITS) ? MAX_DATA_BITS : DATA_W;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (saxis.saxis_tvalid_i),
        .wr_data (saxis.saxis_data_i),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign saxis.saxis_tready_o = !fifo_full;

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              two_stop_q, two_stop_d;
    parity_mode_e      par_mode_q, par_mode_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              uart_tx_q, uart_tx_d;
    logic              tx_done_q, tx_done_d;

    logic              bit_end, can_start, start_frame, par_en, par_bit;
    logic [DATA_W-1:0] masked;

    assign bit_end   = (cnt_q == div_q - 1'b1);
    assign can_start = tx_en && !fifo_empty;
    assign par_en    = (par_mode_q != NONE);

    // Parity over only the N character bits; the popped word is valid
    // during START, which is when this result is captured.
    always_comb begin
        masked = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nbits_q)) masked[i] = fifo_rd_data[i];
        end
        case (par_mode_q)
            ODD:     par_bit = ~^masked;
            EVEN:    par_bit = ^masked;
            MARK:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        div_d       = div_q;
        nbits_d     = nbits_q;
        two_stop_d  = two_stop_q;
        par_mode_d  = par_mode_q;
        shreg_d     = shreg_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;
        tx_done_d   = 1'b0;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        if (state_q != IDLE && !bit_end) cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (can_start) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    shreg_d   = fifo_rd_data;
                    parity_d  = par_bit;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == nbits_q - 1'b1) begin
                        bit_idx_d = '0;
                        state_d   = par_en ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == {3'b000, two_stop_q}) begin
                        tx_done_d = 1'b1;
                        if (can_start) start_frame = 1'b1;
                        else           state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: pop the next character and freeze the configuration.
        if (start_frame) begin
            state_d    = START;
            fifo_pop   = 1'b1;
            cnt_d      = '0;
            bit_idx_d  = '0;
            div_d      = (delitel == '0) ? DIV_W'(1) : delitel;
            nbits_d    = clamp_bits(data_bits, CHAR_MAX);
            two_stop_d = stop_bit_num;
            par_mode_d = decode_parity(parity_bit_mode);
        end
    end

    // The line lags the FSM by one clock so it comes straight from a flop.
    always_comb begin
        case (state_q)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = shreg_q[0];
            PARITY:  uart_tx_d = parity_q;
            default: uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_W'(1);
            nbits_q    <= 4'(MIN_DATA_BITS);
            two_stop_q <= 1'b0;
            par_mode_q <= NONE;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            uart_tx_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            two_stop_q <= two_stop_d;
            par_mode_q <= par_mode_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            uart_tx_q  <= uart_tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign uart_tx   = uart_tx_q;
    assign tx_done   = tx_done_q;
    assign tx_busy   = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
module tb_axis_uart_tx_fifo;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] delitel = 32'd4;
  logic [3:0]  data_bits = 4'd8;
  logic        stop_bit_num = 1'b0;
  logic [2:0]  parity_bit_mode = 3'd0;
  logic        tx_en = 1'b0;
  logic        uart_tx;
  logic [4:0]  fifo_level;
  logic        tx_busy;
  logic        tx_done;
  tx_state_e   dbg_state;

  always #5 clk = ~clk;

  axis_uart_tx_fifo_if #(.DATA_W(8)) ifc ();

  axis_uart_tx_fifo #(
    .DATA_W(8),
    .FIFO_DEPTH(16),
    .DIV_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .saxis(ifc),
    .uart_tx(uart_tx),
    .delitel(delitel),
    .data_bits(data_bits),
    .stop_bit_num(stop_bit_num),
    .parity_bit_mode(parity_bit_mode),
    .tx_en(tx_en),
    .fifo_level(fifo_level),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];      // {last_sample_of_frame, line_value}, one per clock
  int          frame_bits[$]; // model output: bit sequence of one frame
  int          starts[$];     // cycle numbers where frames begin on the line
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  bit          in_frame = 1'b0;
  logic [1:0]  e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic build_frame(input logic [7:0] data, input int db, input int pmode, input int stops);
    int n;
    int ones;
    n = (db < 5) ? 5 : ((db > 8) ? 8 : db);
    ones = 0;
    frame_bits.delete();
    frame_bits.push_back(0);
    for (int i = 0; i < n; i++) begin
      frame_bits.push_back(int'(data[i]));
      ones += int'(data[i]);
    end
    case (pmode)
      1: frame_bits.push_back((ones % 2 == 0) ? 1 : 0);
      2: frame_bits.push_back(ones % 2);
      3: frame_bits.push_back(1);
      4: frame_bits.push_back(0);
      default: ;
    endcase
    for (int i = 0; i < (stops != 0 ? 2 : 1); i++) frame_bits.push_back(1);
  endtask

  function automatic logic [31:0] frame_vec();
    logic [31:0] v;
    v = '0;
    foreach (frame_bits[i]) v[i] = frame_bits[i][0];
    return v;
  endfunction

  task automatic expect_frame(input logic [7:0] data);
    int per;
    build_frame(data, int'(data_bits), int'(parity_bit_mode), int'(stop_bit_num));
    per = (delitel == 0) ? 1 : int'(delitel);
    foreach (frame_bits[i]) begin
      for (int k = 0; k < per; k++) begin
        exp_q.push_back({(i == frame_bits.size() - 1) && (k == per - 1), frame_bits[i][0]});
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (tx_done === 1'b1) done_cnt++;
      if (in_frame || uart_tx !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL line_unexpected: got %0b required 1", uart_tx);
          in_frame = 1'b0;
        end else begin
          e = exp_q.pop_front();
          if (!in_frame) starts.push_back(cyc);
          check("line", {31'd0, uart_tx}, {31'd0, e[0]});
          in_frame = !e[1];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    ifc.saxis_data_i = d;
    ifc.saxis_tvalid_i = 1'b1;
    while (ifc.saxis_tready_o !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    ifc.saxis_tvalid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_frame) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("drain_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_cfg(input int div, input int db, input int pm, input int sb);
    delitel = 32'(div);
    data_bits = 4'(db);
    parity_bit_mode = 3'(pm);
    stop_bit_num = sb[0];
  endtask

  // ---------------- stimulus ----------------
  int d0;
  int t;
  logic [7:0] words[17];

  initial begin
    ifc.saxis_data_i = '0;
    ifc.saxis_tvalid_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_tready", {31'd0, ifc.saxis_tready_o}, 32'd1);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    rst_n = 1'b1;

    // hand-computed pins on the model
    build_frame(8'hA5, 8, 0, 0);
    check("model_a5_vec", frame_vec(), 32'h34A);
    check("model_a5_len", frame_bits.size(), 32'd10);
    build_frame(8'h53, 7, 2, 1);
    check("model_53_vec", frame_vec(), 32'h6A6);
    check("model_53_len", frame_bits.size(), 32'd11);
    build_frame(8'h36, 2, 6, 0);
    check("model_edge_vec", frame_vec(), 32'h6C);
    check("model_edge_len", frame_bits.size(), 32'd7);

    // basic frame with latency check
    set_cfg(4, 8, 0, 0);
    tx_en = 1'b1;
    d0 = done_cnt;
    expect_frame(8'hA5);
    send_word(8'hA5);
    check("lat_n_line", {31'd0, uart_tx}, 32'd1);
    check("lat_n_level", {27'd0, fifo_level}, 32'd1);
    @(posedge clk); #1;
    check("lat_n1_line", {31'd0, uart_tx}, 32'd1);
    check("lat_n1_busy", {31'd0, tx_busy}, 32'd1);
    @(posedge clk); #1;
    check("lat_n2_line", {31'd0, uart_tx}, 32'd0);
    wait_drain();
    check("basic_done", done_cnt - d0, 32'd1);
    check("basic_idle_busy", {31'd0, tx_busy}, 32'd0);

    // even parity, 7 bits, 2 stops
    set_cfg(2, 7, 2, 1);
    d0 = done_cnt;
    expect_frame(8'h53);
    send_word(8'h53);
    wait_drain();
    check("even_done", done_cnt - d0, 32'd1);

    // FIFO full with tx disabled
    tx_en = 1'b0;
    set_cfg(1, 8, 0, 0);
    for (int i = 0; i < 17; i++) words[i] = 8'(i * 29 + 3);
    for (int i = 0; i < 15; i++) send_word(words[i]);
    check("fill15_ready", {31'd0, ifc.saxis_tready_o}, 32'd1);
    check("fill15_level", {27'd0, fifo_level}, 32'd15);
    send_word(words[15]);
    check("fill16_ready", {31'd0, ifc.saxis_tready_o}, 32'd0);
    check("fill16_level", {27'd0, fifo_level}, 32'd16);
    @(negedge clk);
    ifc.saxis_data_i = words[16];
    ifc.saxis_tvalid_i = 1'b1;
    repeat (5) @(negedge clk);
    check("hold17_ready", {31'd0, ifc.saxis_tready_o}, 32'd0);
    check("hold17_level", {27'd0, fifo_level}, 32'd16);
    check("hold17_line", {31'd0, uart_tx}, 32'd1);
    for (int i = 0; i < 17; i++) expect_frame(words[i]);
    starts.delete();
    d0 = done_cnt;
    tx_en = 1'b1;
    send_word(words[16]);
    wait_drain();
    check("full_done", done_cnt - d0, 32'd17);
    check("full_starts", starts.size(), 32'd17);
    if (starts.size() == 17) check("full_span", starts[16] - starts[0], 32'd160);
    check("full_level_end", {27'd0, fifo_level}, 32'd0);

    // back-to-back, odd parity, 6 bits, 2 stops: 10 bits of 3 clocks
    tx_en = 1'b0;
    set_cfg(3, 6, 1, 1);
    expect_frame(8'h2D);
    expect_frame(8'h07);
    expect_frame(8'h3F);
    send_word(8'h2D);
    send_word(8'h07);
    send_word(8'h3F);
    starts.delete();
    d0 = done_cnt;
    @(negedge clk);
    tx_en = 1'b1;
    wait_drain();
    check("b2b_done", done_cnt - d0, 32'd3);
    check("b2b_starts", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], 32'd30);
      check("b2b_gap2", starts[2] - starts[1], 32'd30);
    end

    // edge config: behaves as div 1, 5 bits, no parity
    set_cfg(0, 2, 6, 0);
    d0 = done_cnt;
    starts.delete();
    expect_frame(8'h36);
    expect_frame(8'hE9);
    send_word(8'h36);
    send_word(8'hE9);
    wait_drain();
    check("edge_done", done_cnt - d0, 32'd2);
    if (starts.size() == 2) check("edge_gap", starts[1] - starts[0], 32'd7);
    else check("edge_starts", starts.size(), 32'd2);

    // reset in the middle of a frame
    set_cfg(4, 8, 0, 0);
    expect_frame(8'h3C);
    send_word(8'h3C);
    send_word(8'h81);
    send_word(8'h42);
    t = 0;
    while (dbg_state != DATA && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_data", (dbg_state == DATA) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_line", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    check("post_rst_done", done_cnt - d0, 32'd0);
    check("post_rst_level", {27'd0, fifo_level}, 32'd0);
    check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
